lcd_ctrl: RTL and testbench

- Hardware HD44780 character-LCD write engine for the pipelined RISC-V core's IO subsystem.
- It sits between a CPU-side byte-write handshake and the physical LCD pins. The pins are presented in the core's packed LCD register format, so `o_io_lcd` can drive the board's top-level `o_io_lcd` unchanged.
- It runs the power-on init sequence itself, then turns each accepted command or character byte into a correctly timed RS/EN/DATA bus cycle. After each byte it waits out the LCD execution time before accepting the next.

---
 rtl/lcd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lcd_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD write engine: power-on init, then one timed RS/EN/DATA
// bus cycle per accepted byte, followed by the LCD execution wait.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// PWR_WAIT | power-on delay before the first init byte (ON rises here)
// SETUP    | RS/DATA driven, EN low, for T_SU cycles
// PULSE    | EN high for T_PW cycles
// HOLD     | EN low, RS/DATA held, for T_H cycles
// EXEC     | LCD execution wait (T_CLR for clear/home, else T_EXEC)
// IDLE     | init complete, ready to accept a byte
module lcd_ctrl #(
  parameter int unsigned T_PWR  = 750000,
  parameter int unsigned T_SU   = 3,
  parameter int unsigned T_PW   = 13,
  parameter int unsigned T_H    = 2,
  parameter int unsigned T_EXEC = 2000,
  parameter int unsigned T_CLR  = 80000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_rs,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic        o_init_done,
  output logic [31:0] o_io_lcd
);

  localparam logic [2:0] S_PWR_WAIT = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_PULSE    = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_EXEC     = 3'd4;
  localparam logic [2:0] S_IDLE     = 3'd5;

  // The power-on count is armed on the first edge after reset release, so it
  // loads one less than the other states to keep PWR_WAIT at exactly T_PWR cycles.
  localparam logic [19:0] LD_PWR  = (T_PWR > 1) ? 20'(T_PWR - 2) : 20'd0;
  localparam logic [19:0] LD_SU   = 20'(T_SU - 1);
  localparam logic [19:0] LD_PW   = 20'(T_PW - 1);
  localparam logic [19:0] LD_H    = 20'(T_H - 1);
  localparam logic [19:0] LD_EXEC = 20'(T_EXEC - 1);
  localparam logic [19:0] LD_CLR  = 20'(T_CLR - 1);

  logic [2:0]  state;
  logic [19:0] cnt;
  logic [1:0]  idx;
  logic        on;
  logic        en;
  logic        rs;
  logic [7:0]  data;
  logic        init_done;
  logic        cnt_zero;
  logic        pwr_done;
  logic        slow_cmd;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // Terminal-count and command-class decode for the sequencer.
  always_comb begin
    cnt_zero = (cnt == 20'd0);
    pwr_done = on ? cnt_zero : (T_PWR == 1);
    slow_cmd = !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  end

  // Sequencer: state, down-counter, init index and registered pin values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= S_PWR_WAIT;
      cnt       <= 20'd0;
      idx       <= 2'd0;
      on        <= 1'b0;
      en        <= 1'b0;
      rs        <= 1'b0;
      data      <= 8'h00;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_PWR_WAIT: begin
          on <= 1'b1;
          if (pwr_done) begin
            rs    <= 1'b0;
            data  <= init_byte(2'd0);
            idx   <= 2'd0;
            cnt   <= LD_SU;
            state <= S_SETUP;
          end else begin
            cnt <= on ? cnt - 20'd1 : LD_PWR;
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            en    <= 1'b1;
            cnt   <= LD_PW;
            state <= S_PULSE;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        S_PULSE: begin
          if (cnt_zero) begin
            en    <= 1'b0;
            cnt   <= LD_H;
            state <= S_HOLD;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            cnt   <= slow_cmd ? LD_CLR : LD_EXEC;
            state <= S_EXEC;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        S_EXEC: begin
          if (!cnt_zero) begin
            cnt <= cnt - 20'd1;
          end else if (init_done) begin
            state <= S_IDLE;
          end else if (idx == 2'd3) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            idx   <= idx + 2'd1;
            data  <= init_byte(idx + 2'd1);
            cnt   <= LD_SU;
            state <= S_SETUP;
          end
        end
        S_IDLE: begin
          if (i_valid) begin
            rs    <= i_rs;
            data  <= i_data;
            cnt   <= LD_SU;
            state <= S_SETUP;
          end
        end
        default: begin
          state <= S_PWR_WAIT;
          cnt   <= 20'd0;
        end
      endcase
    end
  end

  // Pin packing: ON, EN, RS, RW=0, DATA; every other bit tied low.
  always_comb begin
    o_io_lcd    = {on, 20'd0, en, rs, 1'b0, data};
    o_ready     = (state == S_IDLE);
    o_init_done = init_done;
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters.
module tb_lcd_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        rs;
  logic [7:0]  data;
  logic        ready;
  logic        init_done;
  logic [31:0] lcd;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int          rise_cyc[$];
  logic [31:0] rise_word[$];
  int          widths[$];
  logic        en_q = 1'b0;
  logic        seen55 = 1'b0;

  lcd_ctrl #(
    .T_PWR(10), .T_SU(2), .T_PW(3), .T_H(1), .T_EXEC(5), .T_CLR(20)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_valid(valid),
    .i_rs(rs),
    .i_data(data),
    .o_ready(ready),
    .o_init_done(init_done),
    .o_io_lcd(lcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter.
  always @(posedge clk) cyc++;

  // Record every EN pulse (rise edge index, bus word, width) and watch for 0x55.
  always @(negedge clk) begin
    if (lcd[10] && !en_q) begin
      rise_cyc.push_back(cyc);
      rise_word.push_back(lcd);
    end
    if (!lcd[10] && en_q && rise_cyc.size() > 0)
      widths.push_back(cyc - rise_cyc[$]);
    if (lcd[7:0] == 8'h55)
      seen55 = 1'b1;
    en_q = lcd[10];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one byte from an idle negedge; busy = cycles o_ready stays low.
  task automatic do_write(input logic r, input logic [7:0] d, output int busy);
    valid = 1'b1;
    rs    = r;
    data  = d;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    busy = 0;
    while (!ready && busy < 100) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!init_done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, base, wbase, busy;
    rst_n = 1'b0;
    valid = 1'b0;
    rs    = 1'b0;
    data  = 8'h00;

    // 1: reset and init
    repeat (3) @(negedge clk);
    check("rst_lcd", lcd, 32'h0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_done", {31'd0, init_done}, 32'd0);
    base  = rise_cyc.size();
    wbase = widths.size();
    rst_n = 1'b1;
    wait_done(n);
    check("init_latency", n, 69);
    check("init_ready", {31'd0, ready}, 32'd1);
    check("init_pulses", rise_cyc.size() - base, 4);
    if (rise_cyc.size() - base == 4 && widths.size() - wbase == 4) begin
      check("init_b0", rise_word[base], 32'h8000_0438);
      check("init_b1", rise_word[base+1], 32'h8000_040C);
      check("init_b2", rise_word[base+2], 32'h8000_0401);
      check("init_b3", rise_word[base+3], 32'h8000_0406);
      check("init_first_rise", rise_cyc[base] - (cyc - 69), 12);
      check("init_w0", widths[wbase], 3);
      check("init_w2", widths[wbase+2], 3);
      check("init_space01", rise_cyc[base+1] - rise_cyc[base], 11);
      check("init_space23_clr", rise_cyc[base+3] - rise_cyc[base+2], 26);
    end

    // 2: character write
    base  = rise_cyc.size();
    wbase = widths.size();
    do_write(1'b1, 8'h41, busy);
    check("chr_busy", busy, 11);
    check("chr_pulses", rise_cyc.size() - base, 1);
    if (rise_cyc.size() > base) check("chr_word", rise_word[base], 32'h8000_0641);
    if (widths.size() > wbase) check("chr_width", widths[wbase], 3);
    check("chr_idle_bus", lcd, 32'h8000_0241);

    // 3: clear vs data timing
    do_write(1'b0, 8'h01, busy);
    check("clr_busy", busy, 26);
    do_write(1'b0, 8'h80, busy);
    check("cmd80_busy", busy, 11);
    do_write(1'b1, 8'h01, busy);
    check("dat01_busy", busy, 11);

    // 4a: back-to-back with i_valid held; period is 11 busy cycles plus the accept cycle
    base  = rise_cyc.size();
    valid = 1'b1;
    rs    = 1'b1;
    data  = 8'h48;
    @(posedge clk);
    #1 data = 8'h49;
    @(negedge clk);
    wait_ready();
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    wait_ready();
    check("b2b_pulses", rise_cyc.size() - base, 2);
    if (rise_cyc.size() - base == 2) begin
      check("b2b_w0", rise_word[base], 32'h8000_0648);
      check("b2b_w1", rise_word[base+1], 32'h8000_0649);
      check("b2b_space", rise_cyc[base+1] - rise_cyc[base], 12);
    end

    // 4b: one-cycle request during a busy transaction is dropped
    base  = rise_cyc.size();
    valid = 1'b1;
    rs    = 1'b1;
    data  = 8'h42;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (4) @(negedge clk);
    valid = 1'b1;
    data  = 8'h55;
    @(negedge clk);
    valid = 1'b0;
    wait_ready();
    repeat (3) @(negedge clk);
    check("busy_ign_ready", {31'd0, ready}, 32'd1);
    check("busy_ign_55", {31'd0, seen55}, 32'd0);
    check("busy_ign_pulses", rise_cyc.size() - base, 1);
    if (rise_cyc.size() > base) check("busy_ign_word", rise_word[base], 32'h8000_0642);

    // 5: request held through init is not accepted until init completes
    rst_n = 1'b0;
    valid = 1'b1;
    rs    = 1'b1;
    data  = 8'h5A;
    repeat (2) @(negedge clk);
    base  = rise_cyc.size();
    rst_n = 1'b1;
    wait_done(n);
    check("pre_init_latency", n, 69);
    check("pre_init_pulses", rise_cyc.size() - base, 4);
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    wait_ready();
    check("post_init_pulses", rise_cyc.size() - base, 5);
    if (rise_cyc.size() - base == 5) check("post_init_word", rise_word[base+4], 32'h8000_065A);

    // 6: reset while EN is high
    valid = 1'b1;
    rs    = 1'b1;
    data  = 8'h43;
    @(posedge clk);
    #1 valid = 1'b0;
    n = 0;
    while (!lcd[10] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_en_high", {31'd0, lcd[10]}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_lcd", lcd, 32'h0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_done", {31'd0, init_done}, 32'd0);
    repeat (2) @(negedge clk);
    base  = rise_cyc.size();
    n     = cyc;
    rst_n = 1'b1;
    busy  = 0;
    while (rise_cyc.size() == base && busy < 100) begin
      @(negedge clk);
      busy++;
    end
    check("rerun_pulse", rise_cyc.size() - base, 1);
    if (rise_cyc.size() > base) begin
      check("rerun_word", rise_word[base], 32'h8000_0438);
      check("rerun_rise", rise_cyc[base] - n, 12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
